mdu_hilo: RTL and testbench
===========================

// Module: mdu_hilo
// PURPOSE
//  Multiply/divide unit for the pipelined MIPS core, successor to the combinational ALU op decoder.
//  Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from opcode/func and runs iterative (1 bit/cycle) mult/div.
//  Owns the architectural HI/LO registers. Sits beside the EX-stage ALU and stalls the pipeline on HI/LO hazards.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; iteration count = WIDTH; counter width $clog2(WIDTH+1)
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      synchronous, active-high
//  valid_i   in   1      EX-stage instruction valid (not bubble)
//  flush_i   in   1      EX-stage instruction killed this cycle
//  opcode    in   6      instruction[31:26]
//  func      in   6      instruction[5:0]
//  rs_val    in   WIDTH  rs operand (dividend / multiplicand / mthi,mtlo data)
//  rt_val    in   WIDTH  rt operand (divisor / multiplier)
//  stall_o   out  1      hold IF/ID/EX; instruction in EX not accepted
//  busy_o    out  1      mult/div in flight
//  rd_val_o  out  WIDTH  MFHI/MFLO result (combinational from HI/LO)
//  hi_o      out  WIDTH  HI register
//  lo_o      out  WIDTH  LO register
// BEHAVIOUR
//  Decode (opcode==6'b000000): func 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU,
//   010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO; all else: not an MDU op (no effect, no stall).
//  accept = valid_i & ~flush_i & MDU-op & ~stall_o.
//  Reset: state=IDLE, HI=LO=0, counter=0, busy_o=0, stall_o=0, rd_val_o=0.
//  FSM: IDLE -> MUL | DIV on accepted mult/div edge (E0); operands captured, signed ops store |x| + sign flags.
//   MUL/DIV: one shift-add (mult) or restoring shift-subtract (div) step per cycle, edges E1..E_WIDTH.
//   -> FIX after step WIDTH; FIX (edge E_WIDTH+1): apply sign correction, write HI/LO, -> IDLE.
//  busy_o=1 in MUL, DIV, FIX: exactly WIDTH+1 cycles; new HI/LO visible first cycle after FIX.
//  stall_o = busy_o & valid_i & ~flush_i & MDU-op (any mult/div/mf/mt waits; non-MDU ops flow).
//  MTHI/MTLO accepted in IDLE: HI/LO <= rs_val at that edge. MFHI/MFLO: rd_val_o = HI/LO when not stalled, else 0.
//  Mult result: {HI,LO} = 2*WIDTH-bit product; signed: negate if sign(rs)^sign(rt).
//  Div result: LO=quotient, HI=remainder; signed: quotient negated if signs differ, remainder takes sign of rs.
//  Div by zero (rt==0): HI=rs_val, LO={WIDTH{1'b1}}, still WIDTH+1 cycles (deterministic timing).
//  Signed overflow (rs=most-negative, rt=-1): LO=most-negative, HI=0 (falls out of unsigned-magnitude path).
//  flush_i never aborts an in-flight op (already architecturally committed at accept).
//  reset mid-operation: FSM->IDLE, HI/LO->0, result discarded, busy_o=0 next cycle.
//  Simultaneous accept of MT* and completion impossible (stall_o blocks during busy).
// STRUCTURE
//  mdu_pkg: func/opcode localparams (FUNC_MULT..FUNC_MTLO, OP_RTYPE), state enum {IDLE,MUL,DIV,FIX},
//   mdu_op_e decoded-op enum.
//  Sub-module mdu_iter_core: WIDTH-parameterised shift/add/subtract datapath + step counter,
//   start/mode/done interface; mdu_hilo keeps decode, FSM, sign fix-up, HI/LO, stall logic.
// TESTING (WIDTH=32)
//  MULT rs=3, rt=-5 -> after 33 busy cycles HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; MULTU same operands -> HI=2, LO=32'hFFFFFFF1.
//  DIV rs=-7, rt=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU rs=7, rt=2 -> LO=3, HI=1.
//  DIV rs=32'h80000000, rt=-1 -> LO=32'h80000000, HI=0; DIVU rs=9, rt=0 -> HI=9, LO=32'hFFFFFFFF.
//  MULT then MFLO next cycle -> stall_o=1 for 33 cycles, then rd_val_o=LO; interleaved ADD not stalled.
//  MTHI 32'hDEADBEEF, then MFHI -> rd_val_o=32'hDEADBEEF, no stall; MULT with flush_i=1 -> not started, busy_o stays 0.
//  reset asserted mid-DIV (cycle 10) -> next cycle busy_o=0, HI=LO=0; subsequent MULT runs normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared decode constants, state and operation enums for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } mdu_state_e;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MFHI,
        OP_MFLO,
        OP_MTHI,
        OP_MTLO
    } mdu_op_e;

    // Map opcode/func onto the MDU operation; anything else is OP_NONE.
    function automatic mdu_op_e decode_op(input logic [5:0] opc, input logic [5:0] fn);
        mdu_op_e op;
        op = OP_NONE;
        if (opc == OP_RTYPE) begin
            case (fn)
                FUNC_MULT:  op = OP_MULT;
                FUNC_MULTU: op = OP_MULTU;
                FUNC_DIV:   op = OP_DIV;
                FUNC_DIVU:  op = OP_DIVU;
                FUNC_MFHI:  op = OP_MFHI;
                FUNC_MFLO:  op = OP_MFLO;
                FUNC_MTHI:  op = OP_MTHI;
                FUNC_MTLO:  op = OP_MTLO;
                default:    op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative unsigned datapath: one shift-add multiply or one restoring
// shift-subtract divide step per cycle, WIDTH steps per operation.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             r_run;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic [WIDTH:0]   r_acc;   // mult: running high half; div: partial remainder
    logic [WIDTH-1:0] r_q;     // mult: multiplier shifting out / product low half; div: dividend in, quotient out
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;

    // Step arithmetic shared by both modes.
    always_comb begin
        w_sum   = r_acc + {1'b0, r_b};
        w_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_b});
    end

    assign o_done = r_run && (r_cnt == LAST);
    assign o_hi   = r_acc[WIDTH-1:0];
    assign o_lo   = r_q;

    // Step counter: runs exactly WIDTH steps after a start.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (r_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_run <= 1'b0;
            end
        end
    end

    // Operand load and one datapath step per running cycle.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_div <= i_div;
            r_acc <= '0;
            r_q   <= i_a;
            r_b   <= i_b;
        end else if (r_run) begin
            if (r_div) begin
                if (w_ge) begin
                    r_acc <= w_shift - {1'b0, r_b};
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= w_shift;
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (r_q[0]) begin
                    {r_acc, r_q} <= {1'b0, w_sum, r_q[WIDTH-1:1]};
                end else begin
                    {r_acc, r_q} <= {1'b0, r_acc, r_q[WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit beside the EX-stage ALU: decodes MDU instructions,
// sequences the iterative core, applies sign fix-up, owns HI/LO and stalls on hazards.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] rd_val_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    mdu_state_e       r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_res;   // negate product / quotient
    logic             r_neg_rem;   // remainder takes dividend's sign
    logic             r_dz;        // divisor was zero

    mdu_op_e          w_op;
    logic             w_is_mdu;
    logic             w_req;
    logic             w_accept;
    logic             w_signed;
    logic             w_start;
    logic             w_start_div;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_done;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic [2*WIDTH-1:0] w_prod;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // Decode, hazard stall and start qualification.
    always_comb begin
        w_op        = decode_op(opcode, func);
        w_is_mdu    = (w_op != OP_NONE);
        w_req       = valid_i & ~flush_i & w_is_mdu;
        w_accept    = w_req & ~stall_o;
        w_signed    = (w_op == OP_MULT) || (w_op == OP_DIV);
        w_start_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
        w_start     = w_accept && (r_state == IDLE) &&
                      ((w_op == OP_MULT) || (w_op == OP_MULTU) || w_start_div);
        w_a         = w_signed ? abs_val(rs_val) : rs_val;
        w_b         = w_signed ? abs_val(rt_val) : rt_val;
        w_prod      = cond_neg2(r_neg_res, {w_core_hi, w_core_lo});
    end

    assign busy_o   = (r_state != IDLE);
    assign stall_o  = busy_o & w_req;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;
    assign rd_val_o = stall_o             ? '0   :
                      (w_op == OP_MFHI)   ? r_hi :
                      (w_op == OP_MFLO)   ? r_lo : '0;

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .i_rst   (reset),
        .i_start (w_start),
        .i_div   (w_start_div),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_done  (w_done),
        .o_hi    (w_core_hi),
        .o_lo    (w_core_lo)
    );

    // Sequencing FSM plus architectural HI/LO update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_MULT, OP_MULTU: begin
                                r_state   <= MUL;
                                r_is_div  <= 1'b0;
                                r_neg_res <= w_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                r_neg_rem <= 1'b0;
                                r_dz      <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_state   <= DIV;
                                r_is_div  <= 1'b1;
                                r_neg_res <= w_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                r_neg_rem <= w_signed & rs_val[WIDTH-1];
                                r_dz      <= (rt_val == '0);
                            end
                            OP_MTHI: r_hi <= rs_val;
                            OP_MTLO: r_lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (w_done) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_is_div) begin
                        r_hi <= cond_neg(r_neg_rem, w_core_hi);
                        r_lo <= r_dz ? '1 : cond_neg(r_neg_res, w_core_lo);
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: mult/div results, edge cases, hazard stalls, MT/MF, flush and reset.
module tb_mdu_hilo;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        flush_i;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall_o;
    logic        busy_o;
    logic [31:0] rd_val_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .flush_i  (flush_i),
        .opcode   (opcode),
        .func     (func),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .rd_val_o (rd_val_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div, wait for completion, check busy length and HI/LO.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        opcode = 6'd0; func = f; rs_val = a; rt_val = b; valid_i = 1'b1;
        tick();
        valid_i = 1'b0; func = F_ADD;
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            tick();
        end
        chk({tag, " cycles"}, 32'(n), 32'd33);
        chk({tag, " hi"}, hi_o, eh);
        chk({tag, " lo"}, lo_o, el);
    endtask

    initial begin
        int n;
        reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        opcode = 6'd0; func = F_ADD; rs_val = '0; rt_val = '0;
        tick(); tick();
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst stall", 32'(stall_o), 32'd0);
        chk("rst hi", hi_o, 32'd0);
        chk("rst lo", lo_o, 32'd0);
        chk("rst rd", rd_val_o, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult", F_MULT, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", F_MULTU, 32'd3, 32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFF1);
        run_op("mult minmin", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("div ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_op("divu dz", F_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
        run_op("div dz neg", F_DIV, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF);

        // MULT followed by MFLO: hazard stall, ADD flows through.
        opcode = 6'd0; func = F_MULT; rs_val = 32'd6; rt_val = 32'd7; valid_i = 1'b1;
        tick();
        func = F_ADD; #1;
        chk("add busy", 32'(busy_o), 32'd1);
        chk("add stall", 32'(stall_o), 32'd0);
        func = F_MFLO; #1;
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            tick();
        end
        chk("mflo stall cycles", 32'(n), 32'd33);
        chk("mflo rd", rd_val_o, 32'd42);
        chk("mflo hi", hi_o, 32'd0);
        tick();
        valid_i = 1'b0; func = F_ADD;

        // MTHI/MTLO then MFHI/MFLO, no stalls.
        func = F_MTHI; rs_val = 32'hDEADBEEF; valid_i = 1'b1; #1;
        chk("mthi stall", 32'(stall_o), 32'd0);
        tick();
        chk("mthi hi", hi_o, 32'hDEADBEEF);
        func = F_MTLO; rs_val = 32'h12345678;
        tick();
        chk("mtlo lo", lo_o, 32'h12345678);
        func = F_MFHI;
        #1;
        chk("mfhi rd", rd_val_o, 32'hDEADBEEF);
        chk("mfhi stall", 32'(stall_o), 32'd0);
        func = F_ADD;
        #1;
        chk("add rd", rd_val_o, 32'd0);
        tick();

        // Flushed MULT never starts.
        func = F_MULT; rs_val = 32'd5; rt_val = 32'd5; flush_i = 1'b1;
        tick();
        chk("flush busy", 32'(busy_o), 32'd0);
        chk("flush lo", lo_o, 32'h12345678);
        flush_i = 1'b0; valid_i = 1'b0; func = F_ADD;
        tick();

        // Reset in the middle of a DIV.
        func = F_DIVU; rs_val = 32'd100; rt_val = 32'd7; valid_i = 1'b1;
        tick();
        valid_i = 1'b0; func = F_ADD;
        for (int i = 0; i < 9; i++) tick();
        chk("middiv busy", 32'(busy_o), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst busy", 32'(busy_o), 32'd0);
        chk("midrst hi", hi_o, 32'd0);
        chk("midrst lo", lo_o, 32'd0);
        reset = 1'b0;
        tick();
        run_op("post rst mult", F_MULT, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("post rst divu", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
